// File: rtl/sd_sector_manager.sv
// sd_sector_manager
// Sequences an SPI-mode SD card controller on behalf of a single host.
// The host loads or unloads a 512-byte sector buffer while the manager is
// idle, then issues one-sector read or write commands. The manager drives
// the controller's rd/wr/address, moves bytes between the controller and
// the buffer, reports completion and status, and resets a hung card.
//
// Ports:
//   clk, reset                    system clock, synchronous active-high reset
//   cmd_valid/cmd_ready           host command handshake
//   cmd_write, cmd_sector         command direction and sector number
//   done, err, busy               completion pulse, status, in-progress flag
//   buf_addr/buf_we/buf_wdata     host buffer port (write ignored while busy)
//   buf_rdata                     host buffer read data, 1-cycle latency
//   sd_reset, sd_ready            controller reset out, controller ready in
//   sd_rd, sd_wr, sd_address      controller command outputs
//   sd_dout, sd_byte_available    controller read data and its strobe
//   sd_din, sd_ready_for_next_byte controller write data and its strobe
module sd_sector_manager #(
    parameter bit          BYTE_ADDR      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned RESET_HOLD     = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_sector,
    output logic        done,
    output logic        err,
    output logic        busy,
    input  logic [8:0]  buf_addr,
    input  logic        buf_we,
    input  logic [7:0]  buf_wdata,
    output logic [7:0]  buf_rdata,
    output logic        sd_reset,
    input  logic        sd_ready,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [31:0] sd_address,
    input  logic [7:0]  sd_dout,
    input  logic        sd_byte_available,
    output logic [7:0]  sd_din,
    input  logic        sd_ready_for_next_byte
);

    localparam logic [2:0] S_WAIT_INIT = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_XFER      = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_ABORT     = 3'd5;

    logic [2:0]  state;
    logic [7:0]  mem [0:511];
    logic [9:0]  cnt;
    logic        is_write;
    logic        skip;
    logic        issued;
    logic [31:0] wd;
    logic [31:0] hold;
    logic        ba_prev;
    logic        rfnb_prev;
    logic        rdy_prev;
    logic        ba_rise;
    logic        rfnb_rise;
    logic        rdy_fall;
    logic        accept;
    logic        host_we;
    logic        int_we;

    // The controller stretches its strobes over many clocks, so only the
    // rising edge of each level counts as one byte.
    assign ba_rise   = sd_byte_available & ~ba_prev;
    assign rfnb_rise = sd_ready_for_next_byte & ~rfnb_prev;
    assign rdy_fall  = rdy_prev & ~sd_ready;

    assign accept  = (state == S_IDLE) && sd_ready && cmd_valid;
    assign host_we = buf_we && !busy;
    assign int_we  = (state == S_XFER) && !is_write && ba_rise && !cnt[9];

    // Sector buffer storage; host and internal writes never coincide because
    // the host port is shut off for the whole time busy is high.
    always_ff @(posedge clk) begin
        if (host_we) begin
            mem[buf_addr] <= buf_wdata;
        end else if (int_we) begin
            mem[cnt[8:0]] <= sd_dout;
        end
    end

    // Buffer read ports. sd_din always follows buf[cnt], so it settles on
    // buf[0] right after accept and on the next byte two clocks after each
    // consuming write strobe edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_rdata <= 8'd0;
            sd_din    <= 8'd0;
        end else begin
            if (!busy) begin
                buf_rdata <= mem[buf_addr];
            end
            sd_din <= mem[cnt[8:0]];
        end
    end

    // Command sequencing, byte counting and the progress watchdog.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_WAIT_INIT;
            cmd_ready  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            sd_reset   <= 1'b0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            sd_address <= 32'd0;
            cnt        <= 10'd0;
            is_write   <= 1'b0;
            skip       <= 1'b0;
            issued     <= 1'b0;
            wd         <= 32'd0;
            hold       <= 32'd0;
            ba_prev    <= 1'b0;
            rfnb_prev  <= 1'b0;
            rdy_prev   <= 1'b0;
        end else begin
            ba_prev   <= sd_byte_available;
            rfnb_prev <= sd_ready_for_next_byte;
            rdy_prev  <= sd_ready;
            done      <= 1'b0;

            case (state)
                S_WAIT_INIT: begin
                    if (sd_ready) begin
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    // Controller was reset behind our back: re-wait for init.
                    if (!sd_ready) begin
                        cmd_ready <= 1'b0;
                        state     <= S_WAIT_INIT;
                    end else if (accept) begin
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        cnt        <= 10'd0;
                        is_write   <= cmd_write;
                        skip       <= cmd_write;
                        issued     <= 1'b0;
                        sd_address <= BYTE_ADDR ? {cmd_sector[22:0], 9'd0} : cmd_sector;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // One settling cycle lets sd_din show buf[0] before wr rises.
                    if (!issued) begin
                        issued <= 1'b1;
                    end else if (!(sd_rd || sd_wr)) begin
                        sd_rd <= !is_write;
                        sd_wr <= is_write;
                    end else if (!sd_ready) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (sd_ready) begin
                        err   <= (cnt != 10'd512);
                        state <= S_DONE;
                    end else if (is_write) begin
                        // The first write strobe arrives during command issue
                        // and consumes nothing.
                        if (rfnb_rise) begin
                            if (skip) begin
                                skip <= 1'b0;
                            end else if (!cnt[9]) begin
                                cnt <= cnt + 10'd1;
                            end
                        end
                    end else if (ba_rise && !cnt[9]) begin
                        cnt <= cnt + 10'd1;
                    end
                end
                S_DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                S_ABORT: begin
                    if (hold == RESET_HOLD - 1) begin
                        sd_reset <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_WAIT_INIT;
                    end else begin
                        hold <= hold + 32'd1;
                    end
                end
                default: begin
                    state <= S_WAIT_INIT;
                end
            endcase

            // Any sign of card progress restarts the watchdog; expiry
            // overrides whatever the state machine chose this cycle.
            if (state == S_ISSUE || state == S_XFER) begin
                if (ba_rise || rfnb_rise || rdy_fall) begin
                    wd <= 32'd0;
                end else if (wd == TIMEOUT_CYCLES - 1) begin
                    err      <= 1'b1;
                    sd_rd    <= 1'b0;
                    sd_wr    <= 1'b0;
                    sd_reset <= 1'b1;
                    hold     <= 32'd0;
                    state    <= S_ABORT;
                end else begin
                    wd <= wd + 32'd1;
                end
            end else begin
                wd <= 32'd0;
            end
        end
    end

endmodule
